// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory handshake
// and the registered instruction presented to the IF/ID register.
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        align_err;

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
    input  imem_ready, imem_rdata,
    output imem_req, imem_addr, pc, pc_next,
    output instr, instr_pc, instr_valid, align_err
  );

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
    output imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc, pc_next,
    input  instr, instr_pc, instr_valid, align_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: next-PC selection, imem req/ready
// handshake, redirect squashing and a one-entry skid for responses under stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_instr_pc, w_instr_pc_next;
  logic        r_instr_valid, w_instr_valid_next;
  logic        r_align_err, w_align_err_next;
  logic        r_pend, w_pend_next;
  logic [31:0] r_pend_target, w_pend_target_next;
  logic        r_skid_valid, w_skid_valid_next;
  logic [31:0] r_skid_data, w_skid_data_next;

  logic        w_req;
  logic        w_resp;
  logic        w_redirect;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus;

  assign w_pc_plus    = r_pc + 32'(PC_STEP);
  assign w_redirect   = bus.jump | bus.branch_taken;
  assign w_raw_target = bus.jump ? bus.jump_target : bus.branch_target;
  assign w_target     = {w_raw_target[31:2], 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
      r_align_err   <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_target <= RESET_PC;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= 32'h0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_instr_valid <= w_instr_valid_next;
      r_align_err   <= w_align_err_next;
      r_pend        <= w_pend_next;
      r_pend_target <= w_pend_target_next;
      r_skid_valid  <= w_skid_valid_next;
      r_skid_data   <= w_skid_data_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_instr_valid_next = r_instr_valid;
    w_align_err_next   = 1'b0;
    w_pend_next        = r_pend;
    w_pend_target_next = r_pend_target;
    w_skid_valid_next  = r_skid_valid;
    w_skid_data_next   = r_skid_data;

    // A parked skid word belongs to the current Pc, so no new request until it drains.
    unique case (r_state)
      S_REQ:   w_req = ~bus.stall & ~r_skid_valid;
      S_WAIT:  w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    w_resp = w_req & bus.imem_ready;

    if (r_state == S_BOOT) w_state_next = S_REQ;

    if (w_redirect) begin
      w_pc_next          = w_target;
      w_instr_valid_next = 1'b0;
      w_align_err_next   = |w_raw_target[1:0];
      w_skid_valid_next  = 1'b0;
      if (w_req && !bus.imem_ready) begin
        // Request still in flight: its response must be swallowed later.
        w_pend_next        = 1'b1;
        w_pend_target_next = w_target;
        w_state_next       = S_WAIT;
      end else begin
        w_pend_next  = 1'b0;
        w_state_next = S_REQ;
      end
    end else if (w_resp) begin
      w_state_next = S_REQ;
      if (r_pend) begin
        w_pend_next        = 1'b0;
        w_pc_next          = r_pend_target;
        w_instr_valid_next = 1'b0;
      end else if (bus.stall) begin
        w_skid_valid_next = 1'b1;
        w_skid_data_next  = bus.imem_rdata;
      end else begin
        w_instr_next       = bus.imem_rdata;
        w_instr_pc_next    = r_pc;
        w_instr_valid_next = 1'b1;
        w_pc_next          = w_pc_plus;
      end
    end else if (bus.stall) begin
      w_state_next = r_state;
      if (r_state == S_BOOT) w_state_next = S_REQ;
    end else if (r_skid_valid) begin
      w_instr_next       = r_skid_data;
      w_instr_pc_next    = r_pc;
      w_instr_valid_next = 1'b1;
      w_pc_next          = w_pc_plus;
      w_skid_valid_next  = 1'b0;
    end else begin
      w_instr_valid_next = 1'b0;
      if (r_state == S_REQ) w_state_next = S_WAIT;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.pc_next     = w_pc_plus;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.align_err   = r_align_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table plus a mid-WAIT
// reset sequence; a second instance starts near the 32-bit wrap point.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus0();
  pc_fetch_unit_if bus1();

  pc_fetch_unit u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  // Memory model: each word encodes its own address.
  assign bus0.imem_rdata = 32'h2000_0001 + bus0.imem_addr;
  assign bus1.imem_rdata = 32'h2000_0001 + bus1.imem_addr;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic        e_align;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(logic st, logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                              logic rd, logic er, logic [31:0] ep, logic ev, logic [31:0] ei,
                              logic ea);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.jmp = jp; v.jt = jt; v.rdy = rd;
    v.e_req = er; v.e_pc = ep; v.e_valid = ev; v.e_ipc = ei; v.e_align = ea;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e_wrap;

    //            st br bt           jp jt            rd | req pc            v  ipc           al
    vecs[0]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0000_0000, 0, 32'h0000_0000, 0);
    vecs[1]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0000_0000, 0);
    vecs[2]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'h0000_0000, 0);
    vecs[3]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'h0000_0004, 0);
    vecs[4]  = mk(0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0000_000C, 1, 32'h0000_0008, 0);
    vecs[5]  = mk(0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0000_000C, 0, 32'h0000_0008, 0);
    vecs[6]  = mk(0, 1, 32'h110,     0, 32'h0,        0,   1, 32'h0000_000C, 0, 32'h0000_0008, 0);
    vecs[7]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0110, 0, 32'h0000_0008, 0);
    vecs[8]  = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0110, 0, 32'h0000_0008, 0);
    vecs[9]  = mk(0, 1, 32'h110,     1, 32'h4000,     1,   1, 32'h0000_0114, 1, 32'h0000_0110, 0);
    vecs[10] = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_4000, 0, 32'h0000_0110, 0);
    vecs[11] = mk(0, 0, 32'h0,       1, 32'h103,      1,   1, 32'h0000_4004, 1, 32'h0000_4000, 0);
    vecs[12] = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0100, 0, 32'h0000_4000, 1);
    vecs[13] = mk(0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0000_0104, 1, 32'h0000_0100, 0);
    vecs[14] = mk(1, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0000_0104, 0, 32'h0000_0100, 0);
    vecs[15] = mk(1, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0104, 0, 32'h0000_0100, 0);
    vecs[16] = mk(1, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0000_0104, 0, 32'h0000_0100, 0);
    vecs[17] = mk(1, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0000_0104, 0, 32'h0000_0100, 0);
    vecs[18] = mk(0, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0000_0104, 0, 32'h0000_0100, 0);
    vecs[19] = mk(0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0000_0108, 1, 32'h0000_0104, 0);
    vecs[20] = mk(0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0000_010C, 1, 32'h0000_0108, 0);

    rst_n = 1'b0;
    bus0.stall = 1'b0; bus0.branch_taken = 1'b0; bus0.branch_target = 32'h0;
    bus0.jump = 1'b0; bus0.jump_target = 32'h0; bus0.imem_ready = 1'b0;
    bus1.stall = 1'b0; bus1.branch_taken = 1'b0; bus1.branch_target = 32'h0;
    bus1.jump = 1'b0; bus1.jump_target = 32'h0; bus1.imem_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk1 ("rst_req",     bus0.imem_req,    1'b0);
    chk32("rst_pc",      bus0.pc,          32'h0);
    chk32("rst_pcnext",  bus0.pc_next,     32'h4);
    chk32("rst_addr",    bus0.imem_addr,   32'h0);
    chk32("rst_instr",   bus0.instr,       32'h0);
    chk1 ("rst_valid",   bus0.instr_valid, 1'b0);
    chk32("rst_pc_wrap", bus1.pc,          32'hFFFF_FFF8);
    $display("reset: pc=%h pc_next=%h req=%b", bus0.pc, bus0.pc_next, bus0.imem_req);

    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus0.stall         = vecs[i].stall;
      bus0.branch_taken  = vecs[i].br;
      bus0.branch_target = vecs[i].bt;
      bus0.jump          = vecs[i].jmp;
      bus0.jump_target   = vecs[i].jt;
      bus0.imem_ready    = vecs[i].rdy;
      #1;
      chk1 ($sformatf("req[%0d]", i),    bus0.imem_req,    vecs[i].e_req);
      chk32($sformatf("pc[%0d]", i),     bus0.pc,          vecs[i].e_pc);
      chk32($sformatf("addr[%0d]", i),   bus0.imem_addr,   vecs[i].e_pc);
      chk32($sformatf("pcnext[%0d]", i), bus0.pc_next,     vecs[i].e_pc + 32'd4);
      chk1 ($sformatf("valid[%0d]", i),  bus0.instr_valid, vecs[i].e_valid);
      chk32($sformatf("ipc[%0d]", i),    bus0.instr_pc,    vecs[i].e_ipc);
      chk1 ($sformatf("align[%0d]", i),  bus0.align_err,   vecs[i].e_align);
      if (vecs[i].e_valid)
        chk32($sformatf("instr[%0d]", i), bus0.instr, 32'h2000_0001 + vecs[i].e_ipc);
      if (i >= 2 && i <= 4) begin
        e_wrap = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        chk1 ($sformatf("wrap_valid[%0d]", i), bus1.instr_valid, 1'b1);
        chk32($sformatf("wrap_ipc[%0d]", i),   bus1.instr_pc,    e_wrap);
        chk32($sformatf("wrap_instr[%0d]", i), bus1.instr,       32'h2000_0001 + e_wrap);
        chk1 ($sformatf("wrap_nox[%0d]", i),   $isunknown(bus1.instr) | $isunknown(bus1.pc), 1'b0);
      end
      if (i == 2) chk32("wrap_pcnext", bus1.pc_next, 32'h0);
      $display("row %0d: req=%b pc=%h valid=%b ipc=%h instr=%h align=%b",
               i, bus0.imem_req, bus0.pc, bus0.instr_valid, bus0.instr_pc, bus0.instr,
               bus0.align_err);
    end

    // Asynchronous reset in the middle of an outstanding request.
    @(negedge clk);
    bus0.imem_ready = 1'b0;
    #1;
    chk1("midwait_req", bus0.imem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1 ("arst_req",    bus0.imem_req,    1'b0);
    chk32("arst_pc",     bus0.pc,          32'h0);
    chk32("arst_addr",   bus0.imem_addr,   32'h0);
    chk32("arst_pcnext", bus0.pc_next,     32'h4);
    chk32("arst_instr",  bus0.instr,       32'h0);
    chk32("arst_ipc",    bus0.instr_pc,    32'h0);
    chk1 ("arst_valid",  bus0.instr_valid, 1'b0);
    chk1 ("arst_align",  bus0.align_err,   1'b0);
    $display("async reset: pc=%h req=%b valid=%b", bus0.pc, bus0.imem_req, bus0.instr_valid);

    @(posedge clk);
    #1 rst_n = 1'b1;
    bus0.imem_ready = 1'b1;
    @(negedge clk); #1;
    chk1("post_boot_req",   bus0.imem_req,    1'b0);
    chk1("post_boot_valid", bus0.instr_valid, 1'b0);
    @(negedge clk); #1;
    chk1 ("post_req1",   bus0.imem_req,    1'b1);
    chk1 ("post_valid1", bus0.instr_valid, 1'b0);
    @(negedge clk); #1;
    chk1 ("post_valid2", bus0.instr_valid, 1'b1);
    chk32("post_ipc2",   bus0.instr_pc,    32'h0);
    chk32("post_instr2", bus0.instr,       32'h2000_0001);
    $display("after reset: valid=%b ipc=%h instr=%h", bus0.instr_valid, bus0.instr_pc, bus0.instr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
